// File: rtl/uart_rx_param_if.sv
// Receiver-side bundle: serial line in, word/strobe/status out.
// master = receiver, slave = consumer that also drives the line.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx;
  logic [DATA_BITS-1:0] data;
  logic                 ready;
  logic                 frame_err;
  logic                 parity_err;
  logic                 busy;

  modport master (
    input  rx,
    output data,
    output ready,
    output frame_err,
    output parity_err,
    output busy
  );

  modport slave (
    output rx,
    input  data,
    input  ready,
    input  frame_err,
    input  parity_err,
    input  busy
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with glitch rejection,
// parity/framing checks and break hold-off.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input logic              ipclk,
  input logic              rst,
  uart_rx_param_if.master  rx_if
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_T = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] FULL_T = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0] LAST_D = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_S = 4'(STOP_BITS - 1);
  localparam logic PAR_TGT = (PARITY == 1) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t               state_q, state_d;
  logic                 rx_s1_q;
  logic                 rx_s_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 ferr_acc_q, ferr_acc_d;
  logic                 perr_acc_q, perr_acc_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 ready_q, ready_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 busy_q, busy_d;

  logic tick;
  logic last_data;
  logic last_stop;
  logic stop_done;
  logic ferr_fin;
  logic is_break;

  // Sample tick and end-of-field qualifiers
  always_comb begin
    tick = 1'b0;
    unique case (state_q)
      S_START:                  tick = (cnt_q == HALF_T);
      S_DATA, S_PARITY, S_STOP: tick = (cnt_q == FULL_T);
      default:                  tick = 1'b0;
    endcase
  end

  assign last_data = (bit_q == LAST_D);
  assign last_stop = (bit_q == LAST_S);
  assign stop_done = (state_q == S_STOP) && tick && last_stop;
  assign ferr_fin  = ferr_acc_q | ~rx_s_q;
  assign is_break  = ferr_fin && (shreg_q == '0);

  // State register, synchroniser and datapath flops
  always_ff @(posedge ipclk or posedge rst) begin
    if (rst) begin
      rx_s1_q      <= 1'b1;
      rx_s_q       <= 1'b1;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shreg_q      <= '0;
      ferr_acc_q   <= 1'b0;
      perr_acc_q   <= 1'b0;
      data_q       <= '0;
      ready_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      rx_s1_q      <= rx_if.rx;
      rx_s_q       <= rx_s1_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shreg_q      <= shreg_d;
      ferr_acc_q   <= ferr_acc_d;
      perr_acc_q   <= perr_acc_d;
      data_q       <= data_d;
      ready_q      <= ready_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (tick) state_d = rx_s_q ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (tick && last_data)
          state_d = (PARITY != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (tick) state_d = S_STOP;
      end
      S_STOP: begin
        if (stop_done)
          state_d = is_break ? S_BREAK : S_IDLE;
      end
      S_BREAK: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Counters, shift register, error accumulation and outputs
  always_comb begin
    cnt_d        = cnt_q + 1'b1;
    bit_d        = bit_q;
    shreg_d      = shreg_q;
    ferr_acc_d   = ferr_acc_q;
    perr_acc_d   = perr_acc_q;
    data_d       = data_q;
    ready_d      = 1'b0;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;
    busy_d       = 1'b0;

    if (state_d != state_q || tick ||
        state_q == S_IDLE || state_q == S_BREAK)
      cnt_d = '0;

    if (state_d != state_q)
      bit_d = '0;
    else if (tick)
      bit_d = bit_q + 1'b1;

    if (state_q == S_START) begin
      ferr_acc_d = 1'b0;
      perr_acc_d = 1'b0;
    end

    if (state_q == S_DATA && tick) begin
      for (int i = 0; i < DATA_BITS; i++) begin
        if (bit_q == 4'(i)) shreg_d[i] = rx_s_q;
      end
    end

    if (state_q == S_PARITY && tick)
      perr_acc_d = ((^shreg_q) ^ rx_s_q) != PAR_TGT;

    if (state_q == S_STOP && tick && !rx_s_q)
      ferr_acc_d = 1'b1;

    if (stop_done) begin
      ready_d      = 1'b1;
      data_d       = shreg_q;
      frame_err_d  = ferr_fin;
      parity_err_d = (PARITY != 0) ? perr_acc_q : 1'b0;
    end

    busy_d = (state_d == S_START) || (state_d == S_DATA) ||
             (state_d == S_PARITY) || (state_d == S_STOP);
  end

  assign rx_if.data       = data_q;
  assign rx_if.ready      = ready_q;
  assign rx_if.frame_err  = frame_err_q;
  assign rx_if.parity_err = parity_err_q;
  assign rx_if.busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: 8N1 and 8E1 instances
// sharing clock and reset, driven with hand-built frames.
module tb_uart_rx_param;

  logic ipclk;
  logic rst;

  uart_rx_param_if #(.DATA_BITS(8)) if_n ();
  uart_rx_param_if #(.DATA_BITS(8)) if_e ();

  uart_rx_param #(
    .CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
  ) dut_n (
    .ipclk(ipclk), .rst(rst), .rx_if(if_n)
  );

  uart_rx_param #(
    .CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)
  ) dut_e (
    .ipclk(ipclk), .rst(rst), .rx_if(if_e)
  );

  int vec;
  int miss;
  int cyc;
  int start_cyc;

  int rdy_cnt_n, rdy_cyc_n, prev_rdy_cyc_n;
  logic [7:0] prev_data_n;
  logic busy_at_rdy_n;
  logic busy_dly_n;
  int busy_rise_n, busy_fall_n;
  int rdy_cnt_e, rdy_cyc_e;

  initial ipclk = 1'b0;
  always #5 ipclk = ~ipclk;

  always @(posedge ipclk) cyc <= cyc + 1;

  // Monitor: ready pulses and busy edges, sampled on falling edge
  always @(negedge ipclk) begin
    if (if_n.ready) begin
      rdy_cnt_n      <= rdy_cnt_n + 1;
      rdy_cyc_n      <= cyc;
      prev_rdy_cyc_n <= rdy_cyc_n;
      prev_data_n    <= if_n.data;
      busy_at_rdy_n  <= if_n.busy;
    end
    if (if_n.busy && !busy_dly_n) busy_rise_n <= cyc;
    if (!if_n.busy && busy_dly_n) busy_fall_n <= cyc;
    busy_dly_n <= if_n.busy;
    if (if_e.ready) begin
      rdy_cnt_e <= rdy_cnt_e + 1;
      rdy_cyc_e <= cyc;
    end
  end

  task automatic drv(input bit sel, input logic v);
    if (sel) if_e.rx = v;
    else     if_n.rx = v;
  endtask

  task automatic bit_out(input bit sel, input logic v);
    @(posedge ipclk);
    #1 drv(sel, v);
    repeat (15) @(posedge ipclk);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d,
                            input bit has_par, input logic par,
                            input logic stop);
    @(posedge ipclk);
    #1 drv(sel, 1'b0);
    start_cyc = cyc;
    repeat (15) @(posedge ipclk);
    for (int i = 0; i < 8; i++) bit_out(sel, d[i]);
    if (has_par) bit_out(sel, par);
    bit_out(sel, stop);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    if_n.rx = 1'b1;
    if_e.rx = 1'b1;
    repeat (3) @(posedge ipclk);
    @(negedge ipclk);
    vec++;
    if (if_n.data !== 8'h00) begin
      miss++;
      $display("FAIL reset_data got %h want 00", if_n.data);
    end
    vec++;
    if (if_n.ready !== 1'b0) begin
      miss++;
      $display("FAIL reset_ready got %b want 0", if_n.ready);
    end
    vec++;
    if (if_n.frame_err !== 1'b0 || if_n.parity_err !== 1'b0) begin
      miss++;
      $display("FAIL reset_err got %b%b want 00",
               if_n.frame_err, if_n.parity_err);
    end
    vec++;
    if (if_n.busy !== 1'b0 || if_e.busy !== 1'b0) begin
      miss++;
      $display("FAIL reset_busy got %b%b want 00", if_n.busy, if_e.busy);
    end
    rst = 1'b0;
    repeat (20) @(posedge ipclk);
    @(negedge ipclk);
    vec++;
    if (rdy_cnt_n !== 0 || if_n.busy !== 1'b0) begin
      miss++;
      $display("FAIL idle_after_reset got rdy=%0d busy=%b want 0 0",
               rdy_cnt_n, if_n.busy);
    end
  endtask

  task automatic test_8n1;
    int c0;
    c0 = rdy_cnt_n;
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
    repeat (20) @(posedge ipclk);
    @(negedge ipclk);
    vec++;
    if (rdy_cnt_n !== c0 + 1) begin
      miss++;
      $display("FAIL a5_ready_count got %0d want %0d", rdy_cnt_n, c0 + 1);
    end
    vec++;
    if (if_n.data !== 8'hA5) begin
      miss++;
      $display("FAIL a5_data got %h want a5", if_n.data);
    end
    vec++;
    if (if_n.frame_err !== 1'b0 || if_n.parity_err !== 1'b0) begin
      miss++;
      $display("FAIL a5_err got %b%b want 00",
               if_n.frame_err, if_n.parity_err);
    end
    vec++;
    if (rdy_cyc_n - start_cyc !== 155) begin
      miss++;
      $display("FAIL a5_latency got %0d want 155", rdy_cyc_n - start_cyc);
    end
    vec++;
    if (busy_at_rdy_n !== 1'b0) begin
      miss++;
      $display("FAIL a5_busy_at_ready got %b want 0", busy_at_rdy_n);
    end
  endtask

  task automatic test_glitch;
    int c0, r0;
    r0 = rdy_cnt_n;
    @(posedge ipclk);
    #1 if_n.rx = 1'b0;
    c0 = cyc;
    repeat (4) @(posedge ipclk);
    #1 if_n.rx = 1'b1;
    repeat (60) @(posedge ipclk);
    @(negedge ipclk);
    vec++;
    if (busy_rise_n - c0 !== 3) begin
      miss++;
      $display("FAIL glitch_busy_rise got %0d want 3", busy_rise_n - c0);
    end
    vec++;
    if (busy_fall_n - busy_rise_n !== 8) begin
      miss++;
      $display("FAIL glitch_busy_len got %0d want 8",
               busy_fall_n - busy_rise_n);
    end
    vec++;
    if (rdy_cnt_n !== r0 || if_n.data !== 8'hA5) begin
      miss++;
      $display("FAIL glitch_no_ready got rdy=%0d data=%h want %0d a5",
               rdy_cnt_n, if_n.data, r0);
    end
  endtask

  task automatic test_parity;
    int r0;
    r0 = rdy_cnt_e;
    send_frame(1'b1, 8'h3C, 1'b1, 1'b1, 1'b1);
    repeat (10) @(posedge ipclk);
    @(negedge ipclk);
    vec++;
    if (rdy_cnt_e !== r0 + 1 || if_e.data !== 8'h3C) begin
      miss++;
      $display("FAIL par_bad_frame got rdy=%0d data=%h want %0d 3c",
               rdy_cnt_e, if_e.data, r0 + 1);
    end
    vec++;
    if (if_e.parity_err !== 1'b1 || if_e.frame_err !== 1'b0) begin
      miss++;
      $display("FAIL par_bad_flags got p=%b f=%b want 1 0",
               if_e.parity_err, if_e.frame_err);
    end
    vec++;
    if (rdy_cyc_e - start_cyc !== 171) begin
      miss++;
      $display("FAIL par_latency got %0d want 171", rdy_cyc_e - start_cyc);
    end
    send_frame(1'b1, 8'h3C, 1'b1, 1'b0, 1'b1);
    repeat (10) @(posedge ipclk);
    @(negedge ipclk);
    vec++;
    if (rdy_cnt_e !== r0 + 2 || if_e.data !== 8'h3C) begin
      miss++;
      $display("FAIL par_good_frame got rdy=%0d data=%h want %0d 3c",
               rdy_cnt_e, if_e.data, r0 + 2);
    end
    vec++;
    if (if_e.parity_err !== 1'b0) begin
      miss++;
      $display("FAIL par_good_flag got %b want 0", if_e.parity_err);
    end
  endtask

  task automatic test_break;
    int r0;
    r0 = rdy_cnt_n;
    send_frame(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge ipclk);
    vec++;
    if (rdy_cnt_n !== r0 + 1 || if_n.data !== 8'h00 ||
        if_n.frame_err !== 1'b1) begin
      miss++;
      $display("FAIL break_ready got rdy=%0d data=%h fe=%b want %0d 00 1",
               rdy_cnt_n, if_n.data, if_n.frame_err, r0 + 1);
    end
    repeat (640) @(posedge ipclk);
    @(negedge ipclk);
    vec++;
    if (rdy_cnt_n !== r0 + 1 || if_n.busy !== 1'b0) begin
      miss++;
      $display("FAIL break_hold got rdy=%0d busy=%b want %0d 0",
               rdy_cnt_n, if_n.busy, r0 + 1);
    end
    if_n.rx = 1'b1;
    repeat (48) @(posedge ipclk);
    send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1);
    repeat (10) @(posedge ipclk);
    @(negedge ipclk);
    vec++;
    if (rdy_cnt_n !== r0 + 2 || if_n.data !== 8'h81 ||
        if_n.frame_err !== 1'b0) begin
      miss++;
      $display("FAIL break_recover got rdy=%0d data=%h fe=%b want %0d 81 0",
               rdy_cnt_n, if_n.data, if_n.frame_err, r0 + 2);
    end
  endtask

  task automatic test_back_to_back;
    int r0;
    r0 = rdy_cnt_n;
    send_frame(1'b0, 8'h01, 1'b0, 1'b0, 1'b1);
    send_frame(1'b0, 8'hFE, 1'b0, 1'b0, 1'b1);
    repeat (10) @(posedge ipclk);
    @(negedge ipclk);
    vec++;
    if (rdy_cnt_n !== r0 + 2) begin
      miss++;
      $display("FAIL b2b_count got %0d want %0d", rdy_cnt_n, r0 + 2);
    end
    vec++;
    if (rdy_cyc_n - prev_rdy_cyc_n !== 160) begin
      miss++;
      $display("FAIL b2b_gap got %0d want 160", rdy_cyc_n - prev_rdy_cyc_n);
    end
    vec++;
    if (prev_data_n !== 8'hFE || if_n.data !== 8'hFE) begin
      miss++;
      $display("FAIL b2b_second got %h/%h want fe", prev_data_n, if_n.data);
    end
  endtask

  task automatic test_rst_mid;
    int r0;
    @(posedge ipclk);
    #1 if_n.rx = 1'b0;
    repeat (15) @(posedge ipclk);
    bit_out(1'b0, 1'b1);
    bit_out(1'b0, 1'b0);
    bit_out(1'b0, 1'b1);
    @(posedge ipclk);
    #1 if_n.rx = 1'b1;
    repeat (7) @(posedge ipclk);
    #3;
    vec++;
    if (if_n.busy !== 1'b1) begin
      miss++;
      $display("FAIL rst_mid_busy_before got %b want 1", if_n.busy);
    end
    r0 = rdy_cnt_n;
    rst = 1'b1;
    #1;
    vec++;
    if (if_n.data !== 8'h00 || if_n.busy !== 1'b0 ||
        if_n.ready !== 1'b0 || if_n.frame_err !== 1'b0) begin
      miss++;
      $display("FAIL rst_mid_async got d=%h b=%b r=%b f=%b want 00 0 0 0",
               if_n.data, if_n.busy, if_n.ready, if_n.frame_err);
    end
    repeat (3) @(negedge ipclk);
    rst = 1'b0;
    repeat (200) @(posedge ipclk);
    @(negedge ipclk);
    vec++;
    if (rdy_cnt_n !== r0 || if_n.busy !== 1'b0) begin
      miss++;
      $display("FAIL rst_mid_discard got rdy=%0d busy=%b want %0d 0",
               rdy_cnt_n, if_n.busy, r0);
    end
    send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
    repeat (10) @(posedge ipclk);
    @(negedge ipclk);
    vec++;
    if (rdy_cnt_n !== r0 + 1 || if_n.data !== 8'h5A ||
        if_n.frame_err !== 1'b0 || if_n.parity_err !== 1'b0) begin
      miss++;
      $display("FAIL rst_mid_5a got rdy=%0d d=%h f=%b p=%b want %0d 5a 0 0",
               rdy_cnt_n, if_n.data, if_n.frame_err, if_n.parity_err,
               r0 + 1);
    end
  endtask

  initial begin
    vec = 0;
    miss = 0;
    cyc = 0;
    start_cyc = 0;
    rdy_cnt_n = 0;
    rdy_cyc_n = 0;
    prev_rdy_cyc_n = 0;
    prev_data_n = 8'h00;
    busy_at_rdy_n = 1'b0;
    busy_dly_n = 1'b0;
    busy_rise_n = 0;
    busy_fall_n = 0;
    rdy_cnt_e = 0;
    rdy_cyc_e = 0;
    test_reset();
    test_8n1();
    test_glitch();
    test_parity();
    test_break();
    test_back_to_back();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
